// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered digit storage.
// Writes land in a shadow buffer; commits copy it to the displayed buffer on frame boundaries only.
module seg_scan_ctrl #(
  parameter int NDIG = 8,
  parameter int DIV  = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            lz_en,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [2:0]      wr_addr,
  input  logic [3:0]      wr_data,
  input  logic            wr_dp,
  input  logic            commit,
  output logic [NDIG-1:0] an_o,
  output logic [7:0]      seg_o
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [0:0] S_OPEN = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [CW-1:0]         cnt;
  logic [2:0]            idx;
  logic [0:0]            state;
  logic [NDIG-1:0][4:0]  shadow, active, shadow_nxt;
  logic [NDIG-1:0]       zf;
  logic                  tick, frame, wr_fire, do_copy, blank;
  logic [4:0]            cur;

  function automatic logic [6:0] seg_pat(input logic [3:0] c);
    case (c)
      4'd0:    seg_pat = 7'b1111110;
      4'd1:    seg_pat = 7'b0110000;
      4'd2:    seg_pat = 7'b1101101;
      4'd3:    seg_pat = 7'b1111001;
      4'd4:    seg_pat = 7'b0110011;
      4'd5:    seg_pat = 7'b1011011;
      4'd6:    seg_pat = 7'b1011111;
      4'd7:    seg_pat = 7'b1110000;
      4'd8:    seg_pat = 7'b1111111;
      4'd9:    seg_pat = 7'b1111011;
      default: seg_pat = 7'b0000000;
    endcase
  endfunction

  assign tick     = (cnt == CW'(DIV - 1)) && en;
  assign frame    = tick && (idx == 3'(NDIG - 1));
  assign wr_ready = (state == S_OPEN);
  assign wr_fire  = wr_valid && wr_ready;
  assign do_copy  = frame && ((state == S_PEND) || commit);

  // Same-cycle write is folded into what gets copied.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      assign shadow_nxt[gi] = (wr_fire && (wr_addr == 3'(gi))) ? {wr_data, wr_dp} : shadow[gi];
      if (gi == NDIG - 1) begin : g_top
        assign zf[gi] = (active[gi] == 5'd0);
      end else begin : g_mid
        assign zf[gi] = (active[gi] == 5'd0) && zf[gi+1];
      end
    end
  endgenerate

  assign cur   = active[idx];
  assign blank = lz_en && (idx != 3'd0) && zf[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == 3'(NDIG - 1)) ? 3'd0 : idx + 3'd1;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OPEN;
    end else if (state == S_OPEN) begin
      if (commit && !frame) state <= S_PEND;
    end else if (frame) begin
      state <= S_OPEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= {NDIG{5'b11110}};
      active <= {NDIG{5'b11110}};
    end else begin
      shadow <= shadow_nxt;
      if (do_copy) active <= shadow_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_o  <= '1;
      seg_o <= 8'hFF;
    end else begin
      an_o  <= en ? ~(NDIG'(1) << idx) : '1;
      seg_o <= (!en || blank) ? 8'hFF : {~seg_pat(cur[4:1]), ~cur[0]};
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: enabled-cycle-count display model checked every cycle, plus literal pins.
module tb_seg_scan_ctrl;
  localparam int NDIG  = 8;
  localparam int DIV   = 4;
  localparam int FRAME = NDIG * DIV;
  localparam logic [7:0] SEGTAB [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                         8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  logic clk = 1'b0, rst_n = 1'b1;
  logic en = 1'b1, lz_en = 1'b0, wr_valid = 1'b0, wr_dp = 1'b0, commit = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic wr_ready;
  logic [NDIG-1:0] an_o;
  logic [7:0] seg_o;

  int total = 0, bad = 0;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lz_en(lz_en), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
    .commit(commit), .an_o(an_o), .seg_o(seg_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: scan position derives from the number of enabled cycles since reset.
  int unsigned m_ticks = 0;
  bit          m_pend = 1'b0;
  logic [4:0]  m_sh [NDIG];
  logic [4:0]  m_ac [NDIG];
  logic [7:0]  e_an = 8'hFF, e_seg = 8'hFF;
  int          m_slot;
  bit          m_frame;

  function automatic logic [7:0] disp(input int s);
    logic [7:0] t;
    bit allz = 1'b1;
    for (int j = s; j < NDIG; j++) if (m_ac[j] != 5'd0) allz = 1'b0;
    if (lz_en && s > 0 && allz) return 8'hFF;
    t = (m_ac[s][4:1] < 4'd10) ? SEGTAB[m_ac[s][4:1]] : 8'h00;
    return {~t[7:1], ~m_ac[s][0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ticks = 0; m_pend = 1'b0; e_an = 8'hFF; e_seg = 8'hFF;
      for (int i = 0; i < NDIG; i++) begin m_sh[i] = 5'h1E; m_ac[i] = 5'h1E; end
    end else begin
      m_slot  = (m_ticks / DIV) % NDIG;
      e_an    = en ? ~(8'd1 << m_slot) : 8'hFF;
      e_seg   = en ? disp(m_slot) : 8'hFF;
      m_frame = en && (((m_ticks + 1) % FRAME) == 0);
      if (wr_valid && !m_pend && wr_addr < NDIG) m_sh[wr_addr] = {wr_data, wr_dp};
      if (m_frame && (m_pend || commit)) begin
        for (int i = 0; i < NDIG; i++) m_ac[i] = m_sh[i];
        m_pend = 1'b0;
      end else if (commit && !m_pend) begin
        m_pend = 1'b1;
      end
      if (en) m_ticks++;
    end
  end

  always @(negedge clk) begin
    chk("model_an", an_o, e_an);
    chk("model_seg", seg_o, e_seg);
    chk("model_rdy", wr_ready, !m_pend);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic dp);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_dp = dp;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic timeout(input string nm);
    total++; bad++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  task automatic wait_phase(input int r);
    int n = 0;
    while ((m_ticks % FRAME) != r && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("wait_phase");
  endtask

  task automatic wait_ready();
    int n = 0;
    while (wr_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("wait_ready");
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    wait_ready();
    cyc(1);
  endtask

  task automatic see_digit(input int k, input logic [7:0] exp, input string nm);
    int n = 0;
    while (an_o !== ~(8'd1 << k) && n < 80) begin @(negedge clk); n++; end
    if (n >= 80) timeout(nm);
    else chk(nm, seg_o, exp);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(3);
    chk("rst_an", an_o, 8'hFF);
    chk("rst_seg", seg_o, 8'hFF);
    chk("rst_rdy", wr_ready, 1'b1);
    rst_n = 1'b1;
    cyc(1);
    chk("scan_an0", an_o, 8'hFE);
    chk("scan_seg0", seg_o, 8'hFF);
    cyc(4);
    chk("scan_an1", an_o, 8'hFD);
    cyc(28);
    chk("scan_wrap", an_o, 8'hFE);

    // Commit mid-frame stays pending until the boundary.
    wr(3'd0, 4'd3, 1'b0);
    wr(3'd1, 4'd7, 1'b1);
    wait_phase(2 * DIV);
    commit = 1'b1;
    cyc(1);
    commit = 1'b0;
    chk("pend_rdy", wr_ready, 1'b0);
    cyc(5);
    chk("pend_rdy2", wr_ready, 1'b0);
    wait_ready();
    see_digit(0, 8'h0D, "d0_three");
    see_digit(1, 8'h1E, "d1_seven_dp");

    // Leading-zero suppression.
    wr(3'd0, 4'd5, 1'b0);
    for (int i = 1; i < NDIG; i++) wr(3'(i), 4'd0, 1'b0);
    do_commit();
    lz_en = 1'b1;
    cyc(FRAME);
    for (int k = NDIG - 1; k >= 1; k--) see_digit(k, 8'hFF, "lz_blank");
    see_digit(0, 8'h49, "lz_d0");
    wr(3'd3, 4'd0, 1'b1);
    do_commit();
    cyc(FRAME);
    for (int k = NDIG - 1; k >= 4; k--) see_digit(k, 8'hFF, "lz_blank_hi");
    see_digit(3, 8'h02, "lz_d3_dp");
    see_digit(2, 8'h03, "lz_d2_zero");
    lz_en = 1'b0;

    // Non-decimal code gives a dark digit.
    wr(3'd4, 4'hA, 1'b0);
    do_commit();
    cyc(FRAME);
    see_digit(4, 8'hFF, "code_a");

    // Write and commit together on the boundary cycle.
    wait_phase(FRAME - 1);
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 4'd9; wr_dp = 1'b0; commit = 1'b1;
    cyc(1);
    wr_valid = 1'b0; commit = 1'b0;
    chk("bound_rdy", wr_ready, 1'b1);
    see_digit(2, 8'h09, "bound_nine");

    // Scan freeze.
    wait_phase(5 * DIV + 1);
    en = 1'b0;
    cyc(2);
    chk("freeze_an", an_o, 8'hFF);
    chk("freeze_seg", seg_o, 8'hFF);
    cyc(8);
    chk("freeze_an10", an_o, 8'hFF);
    en = 1'b1;
    cyc(1);
    chk("resume_an", an_o, 8'hDF);
    cyc(2);
    chk("resume_hold", an_o, 8'hDF);
    cyc(1);
    chk("resume_next", an_o, 8'hBF);

    // Reset while pending drops the commit.
    wr(3'd0, 4'd1, 1'b0);
    wait_phase(2 * DIV);
    commit = 1'b1;
    cyc(1);
    commit = 1'b0;
    chk("pend2_rdy", wr_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", wr_ready, 1'b1);
    chk("arst_an", an_o, 8'hFF);
    chk("arst_seg", seg_o, 8'hFF);
    cyc(2);
    rst_n = 1'b1;
    cyc(FRAME + 2);
    see_digit(0, 8'hFF, "post_rst_d0");
    see_digit(1, 8'hFF, "post_rst_d1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 8, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DIV, default 50000, clock cycles per digit slot (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  scan enable; 0 blanks the display and freezes the scan.
REQ-006 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-007 SHALL have port wr_valid  input  1  write request into the shadow buffer.
REQ-008 SHALL have port wr_ready  output  1  shadow buffer accepting writes.
REQ-009 SHALL have port wr_addr  input  3  digit index; only values below NDIG are used.
REQ-010 SHALL have port wr_data  input  4  BCD digit code.
REQ-011 SHALL have port wr_dp  input  1  decimal point for the digit, 1 = lit.
REQ-012 SHALL have port commit  input  1  single-cycle request to copy the shadow buffer to the active buffer.
REQ-013 SHALL have port an_o  output  NDIG  digit enables, active-low, one-cold.
REQ-014 SHALL have port seg_o  output  8  segments, active-low; bit7..bit1 = a..g, bit0 = dp.

Function
REQ-015 SHALL hold two NDIG-entry buffers (shadow, active), each entry {code[3:0], dp}.
REQ-016 SHALL accept a write when wr_valid && wr_ready; the entry is stored in shadow[wr_addr] on that edge; wr_addr >= NDIG is accepted and discarded.
REQ-017 SHALL run a prescaler 0..DIV-1 while en=1; tick = (cnt==DIV-1) && en; on tick cnt->0 and idx->(idx+1) mod NDIG.
REQ-018 SHALL hold cnt and idx when en=0.
REQ-019 SHALL define the frame boundary as a tick with idx==NDIG-1.
REQ-020 SHALL implement FSM OPEN/PEND: OPEN -> wr_ready=1; PEND -> wr_ready=0 and wr_valid ignored.
REQ-021 SHALL, in OPEN with commit=1 and no frame boundary this cycle, go to PEND.
REQ-022 SHALL, in OPEN with commit=1 on a frame boundary, copy on that edge and stay in OPEN.
REQ-023 SHALL, in PEND on a frame boundary, copy shadow to active on that edge and return to OPEN; commit in PEND is ignored.
REQ-024 SHALL include a write accepted in the same cycle as a copy in the copied data.
REQ-025 SHALL register an_o and seg_o, reflecting idx, active buffer and lz_en from the previous cycle (1-cycle latency).
REQ-026 SHALL drive an_o = ~(1<<idx) when en=1 and all-ones when en=0.
REQ-027 SHALL decode codes 0..9 as active-low patterns: 0:FC, 1:60, 2:DA, 3:F2, 4:66, 5:B6, 6:BE, 7:E0, 8:FE, 9:F6 (inverted); codes 10..15 SHALL give segments a..g off.
REQ-028 SHALL drive bit0 = ~dp for displayed digits.
REQ-029 SHALL, when lz_en=1, blank digit k (seg_o=FF) if every active entry at index >= k has code 0 and dp 0; digit 0 SHALL never be suppressed.
REQ-030 SHALL drive seg_o=FF when en=0.

Reset
REQ-031 SHALL, on rst_n=0, immediately set cnt=0, idx=0, state OPEN, all shadow and active entries {F,0}, an_o=all-ones, seg_o=FF, wr_ready=1.
REQ-032 SHALL abandon a pending commit on reset without copying.

Verification (NDIG=8, DIV=4)
REQ-033 SHALL cover: release rst_n with en=1 -> next cycle an_o=FE, seg_o=FF; 4 cycles later an_o=FD; after 32 cycles wraps to FE.
REQ-034 SHALL cover: write 3 at addr 0, write 7 with dp at addr 1, commit at idx=2 -> wr_ready=0 until the frame boundary; then digit 0 seg_o=0D, digit 1 seg_o=1E.
REQ-035 SHALL cover: active = digit0 5, digits 7..1 0, lz_en=1 -> digits 7..1 FF, digit 0 49; set dp on digit 3 -> digits 7..4 FF, digit 3 02.
REQ-036 SHALL cover: code A committed to addr 4 -> digit 4 seg_o=FF.
REQ-037 SHALL cover: en=0 at idx=5 for 10 cycles -> an_o=FF, seg_o=FF; en=1 -> resumes at idx 5 with cnt unchanged.
REQ-038 SHALL cover: assert rst_n=0 in PEND -> wr_ready=1, an_o=FF, seg_o=FF, and no committed data appears after release.
